// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: round-key constants, controller state type and
// the byte/word transforms used by the iterative key expansion.
package aes128_pkg;

  localparam int AES128_NR        = 10;
  localparam int AES128_NUM_RKEYS = 11;

  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } ks_state_e;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, so 0 maps to 0) plus affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant used when deriving rk(k+1) from rk(k).
  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic rkey_t next_round_key(input rkey_t rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h000000};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64]  ^ n0;
    n2 = rk[63:32]  ^ n1;
    n3 = rk[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes128_key_sched_ctrl_if.sv
// Key-load handshake, status and round-key read port of the key scheduler.
interface aes128_key_sched_ctrl_if;
  import aes128_pkg::*;

  logic       key_valid;
  logic       key_ready;
  rkey_t      cipher_key;
  logic       key_clr;
  logic       busy;
  logic       keys_ready;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic       rd_valid;
  rkey_t      rd_data;
  logic       rd_err;

  modport master (
    output key_valid, cipher_key, key_clr, rd_en, rd_addr,
    input  key_ready, busy, keys_ready, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  key_valid, cipher_key, key_clr, rd_en, rd_addr,
    output key_ready, busy, keys_ready, rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/aes128_key_expansion.sv
// Iterative AES-128 key expansion: one round key per enabled cycle.
// round_key_out one cycle after round_num=k is rk(k+1); round 0 starts
// from cipher_key, later rounds chain from the previous output.
module aes128_key_expansion
  import aes128_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cipher_en,   // shared S-box lent to cipher datapath: stall
  input  logic       rkey_en,
  input  logic [3:0] round_num,
  input  rkey_t      cipher_key,
  output rkey_t      round_key_out
);

  rkey_t base;

  assign base = (round_num == 4'd0) ? cipher_key : round_key_out;

  // Advance one round whenever enabled and the S-box is not lent out.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      round_key_out <= '0;
    else if (rkey_en && !cipher_en)  round_key_out <= next_round_key(base, rcon(round_num));
  end

endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// AES-128 key schedule controller: accepts a cipher key, runs the iterative
// expansion into an 11-entry flop buffer, and serves registered round-key reads.
module aes128_key_sched_ctrl
  import aes128_pkg::*;
#(
  parameter int NUM_RKEYS = AES128_NUM_RKEYS
) (
  input logic                    clk_sys,
  input logic                    rst,
  aes128_key_sched_ctrl_if.slave bus
);

  ks_state_e  state, state_nxt;
  logic [3:0] cnt;
  rkey_t      key_hold;
  rkey_t      rk_buf [NUM_RKEYS];
  rkey_t      round_key_out;
  logic       key_ready, busy, keys_ready, rkey_en, xfer, rd_bad;
  logic       rd_valid, rd_err;
  rkey_t      rd_data;

  aes128_key_expansion u_expand (
    .clk          (clk_sys),
    .rst_n        (~rst),
    .cipher_en    (1'b0),
    .rkey_en      (rkey_en),
    .round_num    (cnt),
    .cipher_key   (key_hold),
    .round_key_out(round_key_out)
  );

  // Next-state and status decode; zeroize beats a simultaneous key offer.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    key_ready  = 1'b0;
    busy       = 1'b0;
    keys_ready = 1'b0;
    rkey_en    = 1'b0;
    case (state)
      IDLE:   key_ready = 1'b1;
      EXPAND: begin
        busy    = 1'b1;
        rkey_en = (cnt <= 4'(AES128_NR - 1));
        if (cnt == 4'(AES128_NR)) state_nxt = READY;
      end
      READY: begin
        key_ready  = 1'b1;
        keys_ready = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    key_ready = key_ready & ~bus.key_clr & ~rst;
    xfer      = bus.key_valid & key_ready;
    if (bus.key_clr)  state_nxt = IDLE;
    else if (xfer)    state_nxt = EXPAND;
  end

  // State register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Round counter, held key and round-key buffer (load, expand, zeroize).
  // NOTE: the buffer is a flop array with reset, not a RAM, because zeroize
  // must clear every entry in a single cycle.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      key_hold <= '0;
      for (int i = 0; i < NUM_RKEYS; i++) rk_buf[i] <= '0;
    end else if (bus.key_clr) begin
      cnt      <= '0;
      key_hold <= '0;
      for (int i = 0; i < NUM_RKEYS; i++) rk_buf[i] <= '0;
    end else if (xfer) begin
      cnt       <= '0;
      key_hold  <= bus.cipher_key;
      rk_buf[0] <= bus.cipher_key;
    end else if (state == EXPAND) begin
      if (cnt != 4'd0)               rk_buf[cnt] <= round_key_out;
      if (cnt < 4'(AES128_NR))       cnt         <= cnt + 4'd1;
    end
  end

  assign rd_bad = ~keys_ready | (bus.rd_addr > 4'(NUM_RKEYS - 1));

  // Registered read port: one-cycle latency, rejected reads return zero data.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= bus.rd_en;
      rd_err   <= bus.rd_en & rd_bad;
      rd_data  <= (bus.rd_en && !rd_bad) ? rk_buf[bus.rd_addr] : '0;
    end
  end

  assign bus.key_ready  = key_ready;
  assign bus.busy       = busy;
  assign bus.keys_ready = keys_ready;
  assign bus.rd_valid   = rd_valid;
  assign bus.rd_err     = rd_err;
  assign bus.rd_data    = rd_data;

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Randomized scoreboard bench for aes128_key_sched_ctrl with a word-level
// FIPS-197 key schedule model and a cycle-count model of the controller.
module tb_aes128_key_sched_ctrl;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes128_key_sched_ctrl_if ks_if ();

  aes128_key_sched_ctrl #(.NUM_RKEYS(11)) dut (
    .clk_sys(clk),
    .rst    (rst),
    .bus    (ks_if)
  );

  typedef struct {
    int           cyc;
    logic         err;
    logic [127:0] data;
  } sb_t;

  sb_t          sb_q[$];
  int           n_pass = 0;
  int           n_total = 0;
  int           cyc = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] m_sched [11];
  int           m_left = 0;
  logic         m_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // S-box from the log/antilog walk over generator 3 (independent of RTL).
  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endfunction

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Whole-schedule expansion, 44 words at once.
  function automatic void build_sched(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_sched[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  // One clock cycle of stimulus: status checks, scoreboard push, model update.
  task automatic drive(input logic kv, input logic [127:0] key, input logic clr,
                       input logic re, input logic [3:0] addr,
                       input logic ovr, input logic o_err, input logic [127:0] o_data);
    logic xfer;
    sb_t  e;
    ks_if.key_valid  = kv;
    ks_if.cipher_key = key;
    ks_if.key_clr    = clr;
    ks_if.rd_en      = re;
    ks_if.rd_addr    = addr;
    #1;
    check("busy", ks_if.busy, m_left > 0);
    check("keys_ready", ks_if.keys_ready, m_ready);
    check("key_ready", ks_if.key_ready, (m_left == 0) && !clr);
    xfer = kv && (m_left == 0) && !clr;
    if (re) begin
      e.cyc = cyc + 1;
      if (ovr) begin
        e.err  = o_err;
        e.data = o_data;
      end else begin
        e.err  = !m_ready || (addr > 4'd10);
        e.data = '0;
        if (!e.err) e.data = m_sched[addr];
      end
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (clr) begin
      m_left  = 0;
      m_ready = 1'b0;
    end else if (xfer) begin
      build_sched(key);
      m_left  = 11;
      m_ready = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input logic [3:0] addr);
    drive(1'b0, '0, 1'b0, 1'b1, addr, 1'b0, 1'b0, '0);
  endtask

  task automatic rd_exp(input logic [3:0] addr, input logic err, input logic [127:0] data);
    drive(1'b0, '0, 1'b0, 1'b1, addr, 1'b1, err, data);
  endtask

  task automatic send(input logic [127:0] key);
    drive(1'b1, key, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd_all();
    for (int i = 0; i < 11; i++) rd(4'(i));
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every read response is matched against the oldest expectation.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (!rst && ks_if.rd_valid) begin
      if (sb_q.size() == 0) begin
        check("rd_valid_spurious", 1'b1, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("rd_latency", cyc, e.cyc);
        check("rd_err", ks_if.rd_err, e.err);
        check("rd_data", ks_if.rd_data, e.data);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, ks_if.busy, 1'b0);
    check({tag, "_keys_ready"}, ks_if.keys_ready, 1'b0);
    check({tag, "_rd_valid"}, ks_if.rd_valid, 1'b0);
    check({tag, "_rd_err"}, ks_if.rd_err, 1'b0);
    check({tag, "_rd_data"}, ks_if.rd_data, '0);
    check({tag, "_key_ready"}, ks_if.key_ready, 1'b0);
  endtask

  initial begin
    build_sbox();
    ks_if.key_valid  = 1'b0;
    ks_if.cipher_key = '0;
    ks_if.key_clr    = 1'b0;
    ks_if.rd_en      = 1'b0;
    ks_if.rd_addr    = '0;

    // Power-on reset.
    #12;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("por_release_key_ready", ks_if.key_ready, 1'b1);

    // Read before any key, then FIPS-197 key with an ignored offer and read mid-expansion.
    rd(4'd0);
    send(FIPS_KEY);
    drive(1'b1, rand_key(), 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, '0);
    idle(10);
    rd_exp(4'd0, 1'b0, FIPS_KEY);
    rd_exp(4'd1, 1'b0, FIPS_RK1);
    rd_exp(4'd10, 1'b0, FIPS_RK10);
    rd_exp(4'd11, 1'b1, '0);
    rd(4'd15);
    rd_all();

    // Rekey from READY with a same-cycle read of the old rk10.
    drive(1'b1, '0, 1'b0, 1'b1, 4'd10, 1'b1, 1'b0, FIPS_RK10);
    idle(11);
    rd_exp(4'd10, 1'b0, ZERO_RK10);

    // Zeroize at cnt=5 together with a key offer.
    send(rand_key());
    idle(5);
    drive(1'b1, rand_key(), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, '0);
    idle(13);
    rd_exp(4'd0, 1'b1, '0);
    rd_all();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) == 0, rand_key(), $urandom_range(0, 99) == 0,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, 1'b0, '0);
    end

    // Full expansions of random keys.
    for (int k = 0; k < 3; k++) begin
      while (m_left > 0) idle(1);
      send(rand_key());
      idle(11);
      rd_all();
    end

    // Asynchronous reset in the middle of an expansion.
    idle(1);
    send(rand_key());
    idle(4);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_left  = 0;
    m_ready = 1'b0;
    #1;
    check("mid_rst_release_key_ready", ks_if.key_ready, 1'b1);
    rd_all();
    idle(12);
    rd_all();
    send(FIPS_KEY);
    idle(11);
    rd_exp(4'd1, 1'b0, FIPS_RK1);

    idle(2);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes128_key_sched_ctrl.md
AES128_KEY_SCHED_CTRL -- requirements
Module: aes128_key_sched_ctrl

Interface
REQ-001 SHALL have parameter NUM_RKEYS, default 11, meaning the number of stored round keys (rk0..rk10); only 11 is legal.
REQ-002 SHALL have port clk_sys  in  1  system clock, all state on the rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous reset, active-high.
REQ-004 SHALL have port key_valid  in  1  new cipher key offered.
REQ-005 SHALL have port key_ready  out  1  controller accepts key; a transfer occurs when key_valid & key_ready.
REQ-006 SHALL have port cipher_key  in  128  AES-128 key, w0 in [127:96].
REQ-007 SHALL have port key_clr  in  1  synchronous zeroize/abort.
REQ-008 SHALL have port busy  out  1  expansion in progress.
REQ-009 SHALL have port keys_ready  out  1  all 11 round keys valid in buffer.
REQ-010 SHALL have port rd_en  in  1  round-key read request.
REQ-011 SHALL have port rd_addr  in  4  round index 0..10.
REQ-012 SHALL have port rd_valid  out  1  read response strobe.
REQ-013 SHALL have port rd_data  out  128  round key for rd_addr.
REQ-014 SHALL have port rd_err  out  1  read rejected, qualified by rd_valid.

Function
REQ-015 SHALL implement FSM states IDLE, EXPAND, READY.
REQ-016 SHALL drive key_ready = (state==IDLE | state==READY) & ~key_clr.
REQ-017 SHALL, on transfer, write cipher_key to buf[0] and to the internal key_hold, clear cnt to 0, and enter EXPAND; keys_ready SHALL be 0 from the next cycle.
REQ-018 SHALL, in EXPAND with counter cnt = 0..10, drive the expansion unit with round_num=cnt and rkey_en=(cnt<=9), and its cipher_key from key_hold.
REQ-019 SHALL, in EXPAND, write buf[cnt] <= expansion round_key_out when cnt>=1, because round_key_out one cycle after round_num=k is rk(k+1).
REQ-020 SHALL move EXPAND -> READY after cnt==10; keys_ready SHALL be 1 exactly 12 cycles after the transfer cycle; busy=1 only in EXPAND.
REQ-021 SHALL accept a new key while in READY (rekey), with behaviour identical to REQ-017.
REQ-022 SHALL, on key_clr in any state, zero all buf entries and key_hold, clear cnt, and go to IDLE next cycle; key_clr SHALL win over a simultaneous key_valid, and no transfer occurs.
REQ-023 SHALL register reads with 1-cycle latency: rd_valid = rd_en delayed one cycle.
REQ-024 SHALL return rd_err=1 and rd_data=0 if, in the rd_en cycle, keys_ready==0 or rd_addr>10.
REQ-025 SHALL otherwise return rd_data=buf[rd_addr] and rd_err=0.
REQ-026 SHALL return pre-update buffer contents for a read in the same cycle as a key transfer; that read SHALL succeed only if keys_ready was 1 in that cycle.
REQ-027 SHALL ignore key_valid in EXPAND; there is no queueing.

Reset
REQ-028 SHALL, on rst, set state=IDLE, cnt=0, buf and key_hold=0, keys_ready=0, busy=0, rd_valid=0, rd_err=0, rd_data=0; key_ready SHALL be 1 once rst deasserts.
REQ-029 SHALL leave no partial keys_ready when rst asserts mid-EXPAND; all round keys SHALL read as errors until a full re-expansion completes.

Structure
REQ-030 SHALL take from shared package aes128_pkg: the state enum, constants AES128_NR=10 and AES128_NUM_RKEYS=11, and the 128-bit round-key typedef.
REQ-031 SHALL instantiate exactly one sub-module, aes128_key_expansion, with rst_n=~rst and cipher_en=0.
REQ-032 SHALL implement buf as 11x128 flops; a RAM macro SHALL NOT be used, because zeroize requires single-cycle clear.

Verification
REQ-033 SHALL check: FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> keys_ready at +12 cycles; rd 0 = 2b7e1516...; rd 1 = a0fafe1788542cb123a339392a6c7605; rd 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 SHALL check: rd_addr=11 while keys_ready -> rd_valid=1, rd_err=1, rd_data=0; rd_en during EXPAND -> rd_err=1.
REQ-035 SHALL check: key_clr at cnt=5 together with key_valid=1 -> IDLE, busy=0, no transfer, all reads give rd_err=1.
REQ-036 SHALL check: rekey from READY with key=0 plus same-cycle rd_en to index 10 -> rd_data=d014f9a8c9ee2589e13f0cc8b6630ca6; after 12 cycles rd 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-037 SHALL check: rst asserted mid-EXPAND -> all outputs 0 asynchronously and key_ready=1 after release.
